// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the add/sub/accumulate datapath.
//   op_e    : operation encoding carried on the op port
//   flags_t : registered result flags {co, ofl, zero}
//   is_acc  : op uses the accumulator as its X operand
//   is_sub  : op uses the subtract form X + ~Y + 1
// Build option: ADDSUB_SATURATE_EN (see addsub_core).
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;

  typedef struct packed {
    logic co;
    logic ofl;
    logic zero;
  } flags_t;

  function automatic logic is_acc(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_sub(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational WIDTH-bit adder/subtractor with carry and
// signed-overflow flags.
// Ports:
//   x, y  in  WIDTH  operands (result = x + y or x - y)
//   sub   in  1      1 = subtract (x + ~y + 1)
//   s     out WIDTH  result (wrapped, or clamped when saturation is built in)
//   co    out 1      carry out of the WIDTH+1 bit sum (1 = no borrow on subtract)
//   ofl   out 1      two's-complement overflow of the unclamped sum
// Build option: ADDSUB_SATURATE_EN defined -> on overflow s clamps to the
// signed max/min matching the sign of x; co/ofl still describe the raw sum.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ofl
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;

  always_comb begin
    y_eff = sub ? ~y : y;
    // The +1 of the two's-complement negate rides in as the carry-in.
    sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    raw   = sum[WIDTH-1:0];
    co    = sum[WIDTH];
    // Overflow: operands agree in sign but the result does not.
    ofl   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
  end

`ifdef ADDSUB_SATURATE_EN
  always_comb begin
    s = raw;
    if (ofl) begin
      s = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign s = raw;
`endif

endmodule

// File: rtl/addsub_acc_pipe.sv
// addsub_acc_pipe: registered add / sub / accumulate-add / accumulate-sub
// unit with carry, overflow and zero flags. One-cycle latency, one result
// per cycle when the consumer keeps out_ready high.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (op, a, b, acc_clr)
//   op                  OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB
//   a, b                operands (b unused for accumulate ops)
//   acc_clr             zero the accumulator with this accepted beat
//   out_valid/out_ready result handshake (s, co, ofl, zero)
//   acc                 current accumulator value
// Build option: ADDSUB_SATURATE_EN enables result clamping in addsub_core;
// the accumulator then loads the clamped value.
//
// Handshake: a beat transfers on a rising edge where valid && ready. A
// producer holding valid keeps its payload stable until the transfer.
// in_ready = !out_valid || out_ready, so the single output register is
// refilled in the same cycle it is drained. While out_valid && !out_ready,
// s/co/ofl/zero/out_valid do not change.
module addsub_acc_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ofl,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] core_s;
  logic             core_co;
  logic             core_ofl;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  flags_t           flags_q;
  logic [WIDTH-1:0] acc_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same beat as an accumulate op takes effect first.
  always_comb begin
    acc_eff = acc_clr ? '0 : acc_q;
    x       = is_acc(op) ? acc_eff : a;
    y       = is_acc(op) ? a : b;
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x   (x),
    .y   (y),
    .sub (is_sub(op)),
    .s   (core_s),
    .co  (core_co),
    .ofl (core_ofl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      if (accept) begin
        out_valid_q  <= 1'b1;
        s_q          <= core_s;
        flags_q.co   <= core_co;
        flags_q.ofl  <= core_ofl;
        flags_q.zero <= (core_s == '0);
        if (is_acc(op)) begin
          acc_q <= core_s;
        end else if (acc_clr) begin
          acc_q <= '0;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = flags_q.co;
  assign ofl       = flags_q.ofl;
  assign zero      = flags_q.zero;
  assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb_addsub_acc_pipe: directed vectors for addsub_acc_pipe (WIDTH=8).
// Driver tasks push hand-computed expectations {s, co, ofl, zero, acc} into
// exp_q when a beat is accepted; a negedge monitor compares every presented
// result against the queue head and pops it on the output handshake.
// Build option: ADDSUB_SATURATE_EN selects the clamped expectations.
module tb_addsub_acc_pipe;
  import addsub_pkg::*;

  localparam int W = 8;
  localparam int EW = 2 * W + 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  op_e          op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         ofl;
  logic         zero;
  logic [W-1:0] acc;

  logic [EW-1:0] exp_q[$];
  int compared;
  int mismatched;

  addsub_acc_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ofl       (ofl),
    .zero      (zero),
    .acc       (acc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (!rst && out_valid) begin
      compared++;
      got = {s, co, ofl, zero, acc};
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: got s=%h co=%b ofl=%b zero=%b acc=%h, required no output",
                 s, co, ofl, zero, acc);
      end else begin
        e = exp_q[0];
        if (got !== e) begin
          mismatched++;
          $display("FAIL result: got s=%h co=%b ofl=%b zero=%b acc=%h, required s=%h co=%b ofl=%b zero=%b acc=%h",
                   s, co, ofl, zero, acc,
                   e[EW-1 -: W], e[W+2], e[W+1], e[W], e[W-1:0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat and hold it until accepted; leaves it driven, so
  // back-to-back calls give one beat per cycle. Call idle() to stop.
  task automatic send(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic clr, input logic [W-1:0] es, input logic eco,
                      input logic eofl, input logic ez, input logic [W-1:0] eacc);
    int n;
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    acc_clr  = clr;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      exp_q.push_back({es, eco, eofl, ez, eacc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || s !== '0 || co !== 1'b0 || ofl !== 1'b0 ||
        zero !== 1'b0 || acc !== '0) begin
      mismatched++;
      $display("FAIL %s: got out_valid=%b s=%h co=%b ofl=%b zero=%b acc=%h, required all 0",
               name, out_valid, s, co, ofl, zero, acc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op         = OP_ADD;
    a          = '0;
    b          = '0;
    acc_clr    = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset_state");
    @(posedge clk);
    #1;

    // Plain add/sub, back to back. Overflow rows depend on the build.
`ifdef ADDSUB_SATURATE_EN
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h00);
`else
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00);
`endif
    send(OP_SUB, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00);
    send(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    send(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
`ifdef ADDSUB_SATURATE_EN
    send(OP_ADD, 8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 8'h00);
    send(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 8'h00);
`else
    send(OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00);
    send(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 8'h00);
`endif

    // Accumulate chain; ADD in the middle leaves acc alone.
    send(OP_ACC_ADD, 8'd10, 8'hAA, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10);
    send(OP_ACC_ADD, 8'd20, 8'hAA, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0, 8'd30);
    send(OP_ACC_ADD, 8'd30, 8'hAA, 1'b0, 8'd60, 1'b0, 1'b0, 1'b0, 8'd60);
    send(OP_ADD,     8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 8'd60);
    send(OP_ACC_SUB, 8'd60, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);

    // ADD with acc_clr zeroes acc; ACC_SUB below zero wraps.
    send(OP_ACC_ADD, 8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05);
    send(OP_ADD,     8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00);
    send(OP_ACC_SUB, 8'h01, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF);

    // acc_clr with no accept, then a stalled consumer with a waiting beat.
    in_valid  = 1'b0;
    acc_clr   = 1'b1;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    op       = OP_ACC_ADD;
    a        = 8'h02;
    b        = 8'h00;
    acc_clr  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_in_ready: got %b, required 0", in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(OP_ACC_ADD, 8'h02, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01);

    // Accumulator overflow: acc follows the (possibly clamped) result.
    send(OP_ACC_ADD, 8'h7F, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F);
`ifdef ADDSUB_SATURATE_EN
    send(OP_ACC_ADD, 8'h01, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h7F);
`else
    send(OP_ACC_ADD, 8'h01, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h80);
`endif

    // Reset while a result is held and acc = 0x3C.
    send(OP_ACC_ADD, 8'h3C, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C);
    idle();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    check_reset_state("mid_op_reset");
    @(posedge clk);
    #1;

    // Recovery after reset.
    send(OP_ADD,     8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
    send(OP_ACC_ADD, 8'h09, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 8'h09);
    idle();

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_out_valid: got %b, required 0", out_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
